// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control -- multi-cycle control unit for the RV32I core.
//
// Sequences the shared ALU / memory / register-file datapath over several
// cycles. Memory accesses use a req/ready handshake with arbitrary wait
// states. All control outputs are decoded combinationally from the current
// state (plus op/funct/branch/mem_ready where relevant) and are forced to 0
// while rst is high.
//
// Optional feature: define MC_PERF_CNT_EN to build the cycle and
// retired-instruction counters. Without it both counter ports read 0 and no
// counter flops exist.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op_i            opcode instr[6:0]
//   funct3_i        instr[14:12]
//   funct7bit_i     instr[30]
//   branch_i        branch-condition result from the ALU
//   mem_ready_i     memory completes the current access this cycle
//   mem_req_o       memory access request
//   AdrSrc_o        0=PC, 1=ALUOut as memory address
//   MemWrite_o      memory write enable
//   IRWrite_o       instruction register load
//   PCWrite_o       PC load
//   RegWrite_o      register file write enable
//   ResultSrc_o     00=ALUOut, 01=mem data, 10=ALUResult
//   ALUSrcA_o       00=PC, 01=OldPC, 10=RD1, 11=zero
//   ALUSrcB_o       00=RD2, 01=ImmExt, 10=constant 4
//   ALUctrl_o       ALU operation code
//   ImmSrc_o        000=I, 001=S, 010=B, 011=U, 100=J
//   state_o         current state code
//   retire_o        one-cycle pulse when an instruction completes
//   illegal_o       high in the ILLEGAL state
//   cycle_cnt_o     cycle counter (MC_PERF_CNT_EN)
//   instret_cnt_o   retired-instruction counter (MC_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module mc_control #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        op_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7bit_i,
    input  logic              branch_i,
    input  logic              mem_ready_i,
    output logic              mem_req_o,
    output logic              AdrSrc_o,
    output logic              MemWrite_o,
    output logic              IRWrite_o,
    output logic              PCWrite_o,
    output logic              RegWrite_o,
    output logic [1:0]        ResultSrc_o,
    output logic [1:0]        ALUSrcA_o,
    output logic [1:0]        ALUSrcB_o,
    output logic [3:0]        ALUctrl_o,
    output logic [2:0]        ImmSrc_o,
    output logic [3:0]        state_o,
    output logic              retire_o,
    output logic              illegal_o,
    output logic [PERF_W-1:0] cycle_cnt_o,
    output logic [PERF_W-1:0] instret_cnt_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_JAL     = 4'd10,
        S_LUI     = 4'd11,
        S_ILLEGAL = 4'd15
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        mem_req_s;
    logic        adr_src_s;
    logic        mem_write_s;
    logic        ir_write_s;
    logic        pc_write_s;
    logic        reg_write_s;
    logic [1:0]  result_src_s;
    logic [1:0]  alu_src_a_s;
    logic [1:0]  alu_src_b_s;
    logic [3:0]  alu_ctrl_s;
    logic [2:0]  imm_src_s;
    logic        retire_s;
    logic        illegal_s;

    // ALU operation from funct3; sub_ok selects SUB for funct3=000 (R-type
    // only, since for I-type instr[30] belongs to the immediate).
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b,
                                              input logic       sub_ok);
        logic [3:0] ctl;
        case (f3)
            3'b000:  ctl = (f7b && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  ctl = ALU_SLL;
            3'b010:  ctl = ALU_SLT;
            3'b011:  ctl = ALU_SLTU;
            3'b100:  ctl = ALU_XOR;
            3'b101:  ctl = f7b ? ALU_SRA : ALU_SRL;
            3'b110:  ctl = ALU_OR;
            3'b111:  ctl = ALU_AND;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    // Immediate format from the opcode; opcodes without an immediate read I.
    function automatic logic [2:0] imm_decode(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            OP_LOAD:  imm = 3'b000;
            OP_ITYPE: imm = 3'b000;
            OP_STORE: imm = 3'b001;
            OP_BRNCH: imm = 3'b010;
            OP_LUI:   imm = 3'b011;
            OP_JAL:   imm = 3'b100;
            default:  imm = 3'b000;
        endcase
        return imm;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and raw control decode.
    always_comb begin
        state_nxt_s  = state_r;
        mem_req_s    = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_ctrl_s   = ALU_ADD;
        imm_src_s    = imm_decode(op_i);
        retire_s     = 1'b0;
        illegal_s    = 1'b0;

        case (state_r)
            S_FETCH: begin
                // PC+4 computed in the same cycle the instruction is fetched.
                mem_req_s    = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = mem_ready_i;
                pc_write_s   = mem_ready_i;
                if (mem_ready_i) begin
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // OldPC + imm: branch target parked in ALUOut.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (op_i)
                    OP_LOAD:  state_nxt_s = S_MEMADR;
                    OP_STORE: state_nxt_s = S_MEMADR;
                    OP_RTYPE: state_nxt_s = S_EXECR;
                    OP_ITYPE: state_nxt_s = S_EXECI;
                    OP_BRNCH: state_nxt_s = S_BRANCH;
                    OP_JAL:   state_nxt_s = S_JAL;
                    OP_LUI:   state_nxt_s = S_LUI;
                    default:  state_nxt_s = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (op_i == OP_LOAD) begin
                    state_nxt_s = S_MEMRD;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (mem_ready_i) begin
                    state_nxt_s = S_MEMWB;
                end else begin
                    state_nxt_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_nxt_s  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_s   = 1'b1;
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (mem_ready_i) begin
                    retire_s    = 1'b1;
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_EXECR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b00;
                alu_ctrl_s  = alu_decode(funct3_i, funct7bit_i, 1'b1);
                state_nxt_s = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_ctrl_s  = alu_decode(funct3_i, funct7bit_i, 1'b0);
                state_nxt_s = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_s = 2'b00;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_nxt_s  = S_FETCH;
            end
            S_BRANCH: begin
                // rs1-rs2 sets the flag; PC takes the target held in ALUOut.
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b00;
                alu_ctrl_s   = ALU_SUB;
                result_src_s = 2'b00;
                pc_write_s   = branch_i;
                retire_s     = 1'b1;
                state_nxt_s  = S_FETCH;
            end
            S_JAL: begin
                // PC <- target from ALUOut while OldPC+4 forms the link value.
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b00;
                pc_write_s   = 1'b1;
                state_nxt_s  = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a_s = 2'b11;
                alu_src_b_s = 2'b01;
                state_nxt_s = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_s   = 1'b1;
                state_nxt_s = S_ILLEGAL;
            end
            default: begin
                // Unused encodings trap rather than run stray enables.
                state_nxt_s = S_ILLEGAL;
            end
        endcase
    end

    // Output gating: everything reads 0 while reset is asserted.
    always_comb begin
        if (rst) begin
            mem_req_o   = 1'b0;
            AdrSrc_o    = 1'b0;
            MemWrite_o  = 1'b0;
            IRWrite_o   = 1'b0;
            PCWrite_o   = 1'b0;
            RegWrite_o  = 1'b0;
            ResultSrc_o = 2'b00;
            ALUSrcA_o   = 2'b00;
            ALUSrcB_o   = 2'b00;
            ALUctrl_o   = 4'b0000;
            ImmSrc_o    = 3'b000;
            state_o     = 4'd0;
            retire_o    = 1'b0;
            illegal_o   = 1'b0;
        end else begin
            mem_req_o   = mem_req_s;
            AdrSrc_o    = adr_src_s;
            MemWrite_o  = mem_write_s;
            IRWrite_o   = ir_write_s;
            PCWrite_o   = pc_write_s;
            RegWrite_o  = reg_write_s;
            ResultSrc_o = result_src_s;
            ALUSrcA_o   = alu_src_a_s;
            ALUSrcB_o   = alu_src_b_s;
            ALUctrl_o   = alu_ctrl_s;
            ImmSrc_o    = imm_src_s;
            state_o     = state_r;
            retire_o    = retire_s;
            illegal_o   = illegal_s;
        end
    end

`ifdef MC_PERF_CNT_EN
    localparam logic [PERF_W-1:0] CNT_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] cycle_cnt_r;
    logic [PERF_W-1:0] instret_cnt_r;

    // Performance counters, wrapping naturally at 2^PERF_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_r   <= {PERF_W{1'b0}};
            instret_cnt_r <= {PERF_W{1'b0}};
        end else begin
            cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
            if (retire_s) begin
                instret_cnt_r <= instret_cnt_r + CNT_ONE;
            end else begin
                instret_cnt_r <= instret_cnt_r;
            end
        end
    end

    assign cycle_cnt_o   = rst ? {PERF_W{1'b0}} : cycle_cnt_r;
    assign instret_cnt_o = rst ? {PERF_W{1'b0}} : instret_cnt_r;
`else
    assign cycle_cnt_o   = {PERF_W{1'b0}};
    assign instret_cnt_o = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mc_control -- directed scoreboard bench for mc_control.
// The stimulus process drives one cycle at a time and pushes the expected
// control vector (plus expected counter values) for that cycle; a separate
// monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_mc_control;

    localparam int PERF_W = 32;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        op_i;
    logic [2:0]        funct3_i;
    logic              funct7bit_i;
    logic              branch_i;
    logic              mem_ready_i;
    logic              mem_req_o;
    logic              AdrSrc_o;
    logic              MemWrite_o;
    logic              IRWrite_o;
    logic              PCWrite_o;
    logic              RegWrite_o;
    logic [1:0]        ResultSrc_o;
    logic [1:0]        ALUSrcA_o;
    logic [1:0]        ALUSrcB_o;
    logic [3:0]        ALUctrl_o;
    logic [2:0]        ImmSrc_o;
    logic [3:0]        state_o;
    logic              retire_o;
    logic              illegal_o;
    logic [PERF_W-1:0] cycle_cnt_o;
    logic [PERF_W-1:0] instret_cnt_o;

    mc_control #(.PERF_W(PERF_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_i          (op_i),
        .funct3_i      (funct3_i),
        .funct7bit_i   (funct7bit_i),
        .branch_i      (branch_i),
        .mem_ready_i   (mem_ready_i),
        .mem_req_o     (mem_req_o),
        .AdrSrc_o      (AdrSrc_o),
        .MemWrite_o    (MemWrite_o),
        .IRWrite_o     (IRWrite_o),
        .PCWrite_o     (PCWrite_o),
        .RegWrite_o    (RegWrite_o),
        .ResultSrc_o   (ResultSrc_o),
        .ALUSrcA_o     (ALUSrcA_o),
        .ALUSrcB_o     (ALUSrcB_o),
        .ALUctrl_o     (ALUctrl_o),
        .ImmSrc_o      (ImmSrc_o),
        .state_o       (state_o),
        .retire_o      (retire_o),
        .illegal_o     (illegal_o),
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_cnt_o (instret_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [24:0]       ctl;
        logic [PERF_W-1:0] cyc;
        logic [PERF_W-1:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          step_no  = 0;
    logic [PERF_W-1:0] mdl_cyc = {PERF_W{1'b0}};
    logic [PERF_W-1:0] mdl_ret = {PERF_W{1'b0}};

    localparam logic [24:0] ZERO = 25'd0;

    // Vector layout: mreq adr mw irw pcw rw res[2] a[2] b[2] alu[4] imm[3] st[4] ret ill
    function automatic logic [24:0] ev(input logic mreq, input logic adr, input logic mw,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] res, input logic [1:0] a,
                                       input logic [1:0] b, input logic [3:0] alu,
                                       input logic [2:0] imm, input logic [3:0] st,
                                       input logic ret, input logic ill);
        return {mreq, adr, mw, irw, pcw, rw, res, a, b, alu, imm, st, ret, ill};
    endfunction

    function automatic logic [24:0] e_fetch(input logic r, input logic [2:0] imm);
        return ev(1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'b10, 2'b00, 2'b10, 4'b0000, imm, 4'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [24:0] e_decode(input logic [2:0] imm);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 4'b0000, imm, 4'd1, 1'b0, 1'b0);
    endfunction
    function automatic logic [24:0] e_memadr(input logic [2:0] imm);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0000, imm, 4'd2, 1'b0, 1'b0);
    endfunction
    function automatic logic [24:0] e_memrd(input logic [2:0] imm);
        return ev(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, imm, 4'd3, 1'b0, 1'b0);
    endfunction
    function automatic logic [24:0] e_memwb(input logic [2:0] imm);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 4'b0000, imm, 4'd4, 1'b1, 1'b0);
    endfunction
    function automatic logic [24:0] e_memwr(input logic r, input logic [2:0] imm);
        return ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, imm, 4'd5, r, 1'b0);
    endfunction
    function automatic logic [24:0] e_execr(input logic [3:0] alu);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, 3'b000, 4'd6, 1'b0, 1'b0);
    endfunction
    function automatic logic [24:0] e_execi(input logic [3:0] alu);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu, 3'b000, 4'd7, 1'b0, 1'b0);
    endfunction
    function automatic logic [24:0] e_aluwb(input logic [2:0] imm);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, imm, 4'd8, 1'b1, 1'b0);
    endfunction
    function automatic logic [24:0] e_branch(input logic br);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, br, 1'b0, 2'b00, 2'b10, 2'b00, 4'b0001, 3'b010, 4'd9, 1'b1, 1'b0);
    endfunction
    function automatic logic [24:0] e_jal();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 4'b0000, 3'b100, 4'd10, 1'b0, 1'b0);
    endfunction
    function automatic logic [24:0] e_lui();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 4'b0000, 3'b011, 4'd11, 1'b0, 1'b0);
    endfunction
    function automatic logic [24:0] e_ill(input logic [2:0] imm);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, imm, 4'd15, 1'b0, 1'b1);
    endfunction

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b);
        op_i        = op;
        funct3_i    = f3;
        funct7bit_i = f7b;
    endtask

    // One clock cycle: drive inputs, post the expectation, advance.
    task automatic cyc(input logic r_in, input logic rdy, input logic br, input logic [24:0] e);
        exp_t rec;
        rst         = r_in;
        mem_ready_i = rdy;
        branch_i    = br;
        rec.ctl     = e;
`ifdef MC_PERF_CNT_EN
        rec.cyc     = r_in ? {PERF_W{1'b0}} : mdl_cyc;
        rec.ret     = r_in ? {PERF_W{1'b0}} : mdl_ret;
`else
        rec.cyc     = {PERF_W{1'b0}};
        rec.ret     = {PERF_W{1'b0}};
`endif
        exp_q.push_back(rec);
        if (r_in) begin
            mdl_cyc = {PERF_W{1'b0}};
            mdl_ret = {PERF_W{1'b0}};
        end else begin
            mdl_cyc = mdl_cyc + 32'd1;
            mdl_ret = mdl_ret + {31'd0, e[1]};
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        exp_t        rec;
        logic [24:0] got;
        if (exp_q.size() > 0) begin
            rec = exp_q.pop_front();
            got = {mem_req_o, AdrSrc_o, MemWrite_o, IRWrite_o, PCWrite_o, RegWrite_o,
                   ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUctrl_o, ImmSrc_o, state_o,
                   retire_o, illegal_o};
            chk_cnt++;
            if (got === rec.ctl && cycle_cnt_o === rec.cyc && instret_cnt_o === rec.ret) begin
                pass_cnt++;
            end else begin
                $display("FAIL cycle_%0d: got ctl=%b cyc=%0d ret=%0d, expected ctl=%b cyc=%0d ret=%0d",
                         step_no, got, cycle_cnt_o, instret_cnt_o, rec.ctl, rec.cyc, rec.ret);
            end
            step_no++;
        end
    end

    initial begin
        rst = 1'b1;
        mem_ready_i = 1'b0;
        branch_i = 1'b0;
        set_instr(OP_RTYPE, 3'b000, 1'b0);
        @(posedge clk);
        #1;

        // Reset: outputs all zero.
        cyc(1'b1, 1'b0, 1'b0, ZERO);
        cyc(1'b1, 1'b1, 1'b0, ZERO);

        // add x3,x1,x2
        set_instr(OP_RTYPE, 3'b000, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_execr(4'b0000));
        cyc(1'b0, 1'b1, 1'b0, e_aluwb(3'b000));

        // sub
        set_instr(OP_RTYPE, 3'b000, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_execr(4'b0001));
        cyc(1'b0, 1'b1, 1'b0, e_aluwb(3'b000));

        // srai
        set_instr(OP_ITYPE, 3'b101, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_execi(4'b0111));
        cyc(1'b0, 1'b1, 1'b0, e_aluwb(3'b000));

        // addi with instr[30]=1 must still be ADD
        set_instr(OP_ITYPE, 3'b000, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_execi(4'b0000));
        cyc(1'b0, 1'b1, 1'b0, e_aluwb(3'b000));

        // xor (R) and sltu (I) spot checks
        set_instr(OP_RTYPE, 3'b100, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_execr(4'b0100));
        cyc(1'b0, 1'b1, 1'b0, e_aluwb(3'b000));
        set_instr(OP_ITYPE, 3'b011, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_execi(4'b1001));
        cyc(1'b0, 1'b1, 1'b0, e_aluwb(3'b000));

        // lw: one fetch wait, then 3 wait cycles in MEMRD
        set_instr(OP_LOAD, 3'b010, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0, 3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b000));
        cyc(1'b0, 1'b0, 1'b0, e_decode(3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_memadr(3'b000));
        cyc(1'b0, 1'b0, 1'b0, e_memrd(3'b000));
        cyc(1'b0, 1'b0, 1'b0, e_memrd(3'b000));
        cyc(1'b0, 1'b0, 1'b0, e_memrd(3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_memrd(3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_memwb(3'b000));

        // sw with one wait state
        set_instr(OP_STORE, 3'b010, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b001));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b001));
        cyc(1'b0, 1'b1, 1'b0, e_memadr(3'b001));
        cyc(1'b0, 1'b0, 1'b0, e_memwr(1'b0, 3'b001));
        cyc(1'b0, 1'b1, 1'b0, e_memwr(1'b1, 3'b001));

        // beq taken, then not taken
        set_instr(OP_BRNCH, 3'b000, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, e_fetch(1'b1, 3'b010));
        cyc(1'b0, 1'b1, 1'b1, e_decode(3'b010));
        cyc(1'b0, 1'b1, 1'b1, e_branch(1'b1));
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b010));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b010));
        cyc(1'b0, 1'b1, 1'b0, e_branch(1'b0));

        // jal
        set_instr(OP_JAL, 3'b000, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b100));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b100));
        cyc(1'b0, 1'b1, 1'b0, e_jal());
        cyc(1'b0, 1'b1, 1'b0, e_aluwb(3'b100));

        // lui
        set_instr(OP_LUI, 3'b000, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b011));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b011));
        cyc(1'b0, 1'b1, 1'b0, e_lui());
        cyc(1'b0, 1'b1, 1'b0, e_aluwb(3'b011));

        // illegal opcode: absorbing for 10 cycles, ready toggling
        set_instr(OP_BAD, 3'b000, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b000));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b000));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, i[0], 1'b1, e_ill(3'b000));
        end
        cyc(1'b1, 1'b1, 1'b0, ZERO);
        cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0, 3'b000));

        // reset during a store wait state
        set_instr(OP_STORE, 3'b010, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b001));
        cyc(1'b0, 1'b1, 1'b0, e_decode(3'b001));
        cyc(1'b0, 1'b1, 1'b0, e_memadr(3'b001));
        cyc(1'b0, 1'b0, 1'b0, e_memwr(1'b0, 3'b001));
        cyc(1'b1, 1'b0, 1'b0, ZERO);
        cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0, 3'b001));
        cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1, 3'b001));

        // Let the monitor drain; bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        chk_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
